mem_port_arbiter: RTL and testbench

- Shares the single synchronous memory between three requesters: instruction fetch (PC side), data load/store (accumulator-addressed side), and a debug/loader port.
- Replaces the fixed clock-phase address mux. Each requester gets a req/gnt/ack handshake.
- Fixed priority applies, with an anti-starvation boost for fetch and a halt mode that gives debug exclusive access.
- Sits between the control unit/PC/accumulator and the memory block.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter in front of a single synchronous memory: instruction fetch,
// data load/store and a debug/loader port. Fixed priority dbg > data > fetch.
// Fetch is promoted above data once it has been refused for WAIT_MAX cycles in
// a row. A halt mode drains the one possible in-flight access and then gives
// the debug port sole ownership of the memory.
module mem_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int WAIT_MAX = 3,
    parameter int CW       = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    // instruction fetch
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_ack,
    // data load/store
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_we,
    output logic          d_gnt,
    output logic          d_ack,
    // debug/loader
    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    input  logic          dbg_we,
    output logic          dbg_gnt,
    output logic          dbg_ack,
    input  logic          dbg_halt,
    output logic          halted,
    // memory side
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DEBUG  = 2'd2
    } state_t;

    // Grant and ack vectors use bit 0 = fetch, bit 1 = data, bit 2 = debug.
    state_t          state_q;
    logic            halted_q;
    logic [2:0]      ack_q;
    logic [CW-1:0]   starv_q;
    logic [CW-1:0]   starv_d;
    logic [AW-1:0]   last_addr_q;
    logic [2:0]      gnt;
    logic            normal_arb;
    logic            boost;
    logic            debug_hold;

    // Leaving DEBUG re-enables normal arbitration in the same cycle that
    // dbg_halt drops, so the state register alone is not enough here.
    assign debug_hold = (state_q == ST_DEBUG) && dbg_halt;
    assign normal_arb = (state_q == ST_NORMAL) || ((state_q == ST_DEBUG) && !dbg_halt);
    assign boost      = (starv_q == CW'(WAIT_MAX)) && if_req;

    // Select at most one winner; nothing is granted while reset is held or while draining.
    always_comb begin
        gnt = 3'b000;
        if (rst_n) begin
            if (normal_arb) begin
                if (dbg_req) begin
                    gnt = 3'b100;
                end else if (boost) begin
                    gnt = 3'b001;
                end else if (d_req) begin
                    gnt = 3'b010;
                end else if (if_req) begin
                    gnt = 3'b001;
                end
            end else if (debug_hold) begin
                gnt = {dbg_req, 2'b00};
            end
        end
    end

    // Steer the winner onto the memory port; an idle port keeps its last address.
    always_comb begin
        mem_addr  = last_addr_q;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (!rst_n) begin
            mem_addr = '0;
        end else if (gnt[2]) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
        end else if (gnt[1]) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
        end else if (gnt[0]) begin
            mem_addr = if_addr;
        end
    end

    // Count consecutive refused fetch cycles, saturating; frozen while debug owns memory.
    always_comb begin
        starv_d = starv_q;
        if (!debug_hold) begin
            if (!if_req || gnt[0]) begin
                starv_d = '0;
            end else if (starv_q != CW'(WAIT_MAX)) begin
                starv_d = starv_q + CW'(1);
            end
        end
    end

    // Halt sequencing: NORMAL -> DRAIN -> DEBUG, with halted registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_NORMAL;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    state_q  <= dbg_halt ? ST_DRAIN : ST_NORMAL;
                    halted_q <= 1'b0;
                end
                ST_DRAIN: begin
                    state_q  <= dbg_halt ? ST_DEBUG : ST_NORMAL;
                    halted_q <= dbg_halt;
                end
                ST_DEBUG: begin
                    state_q  <= dbg_halt ? ST_DEBUG : ST_NORMAL;
                    halted_q <= dbg_halt;
                end
                default: begin
                    state_q  <= ST_NORMAL;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // Acks follow grants by one cycle; reset drops any ack still pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q       <= 3'b000;
            starv_q     <= '0;
            last_addr_q <= '0;
        end else begin
            ack_q   <= gnt;
            starv_q <= starv_d;
            if (gnt != 3'b000) begin
                last_addr_q <= mem_addr;
            end
        end
    end

    assign if_gnt  = gnt[0];
    assign d_gnt   = gnt[1];
    assign dbg_gnt = gnt[2];
    assign if_ack  = ack_q[0];
    assign d_ack   = ack_q[1];
    assign dbg_ack = ack_q[2];
    assign halted  = halted_q;
    assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The driver applies one vector per cycle
// and queues the grant it expects for that cycle plus the ack it expects one
// cycle later; the monitor pops and compares on the falling edge. The memory
// is preloaded with mem[a] = a ^ 8'hA6.
module tb_mem_port_arbiter;

    localparam logic [2:0] G_NO  = 3'b000;
    localparam logic [2:0] G_IF  = 3'b001;
    localparam logic [2:0] G_D   = 3'b010;
    localparam logic [2:0] G_DBG = 3'b100;

    logic       clk;
    logic       rst_n;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_gnt, if_ack;
    logic       d_req;
    logic [7:0] d_addr, d_wdata;
    logic       d_we;
    logic       d_gnt, d_ack;
    logic       dbg_req;
    logic [7:0] dbg_addr, dbg_wdata;
    logic       dbg_we;
    logic       dbg_gnt, dbg_ack;
    logic       dbg_halt;
    logic       halted;
    logic [7:0] mem_addr, mem_wdata, mem_rdata, rdata;
    logic       mem_we;

    logic       mem_init;
    logic       done;
    int         cyc;
    int         checks;
    int         errors;
    bit         finished;

    typedef struct {
        int         cyc;
        logic [2:0] gnt;
        logic       chk_h;
        logic       halt;
        logic       we;
        logic       chk_a;
        logic [7:0] addr;
        logic [7:0] wdata;
    } exp_t;

    typedef struct {
        int         due;
        logic [2:0] port;
        logic       chk_rd;
        logic [7:0] rd;
    } ack_t;

    exp_t exp_q[$];
    ack_t ack_q[$];
    exp_t em;
    ack_t am;
    logic [2:0] acks;

    logic [7:0] tb_mem [256];

    mem_port_arbiter #(.AW(8), .DW(8), .WAIT_MAX(3), .CW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_we      (d_we),
        .d_gnt     (d_gnt),
        .d_ack     (d_ack),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_we    (dbg_we),
        .dbg_gnt   (dbg_gnt),
        .dbg_ack   (dbg_ack),
        .dbg_halt  (dbg_halt),
        .halted    (halted),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .rdata     (rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory model: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 8'(i) ^ 8'hA6;
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= tb_mem[mem_addr];
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Monitor: compare queued expectations against the DUT on the falling edge.
    always @(negedge clk) begin
        if (!finished) begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                em = exp_q.pop_front();
                chk("gnt", {5'd0, dbg_gnt, d_gnt, if_gnt}, {5'd0, em.gnt});
                chk("mem_we", {7'd0, mem_we}, {7'd0, em.we});
                if (em.chk_h) chk("halted", {7'd0, halted}, {7'd0, em.halt});
                if (em.chk_a) chk("mem_addr", mem_addr, em.addr);
                if (em.we) chk("mem_wdata", mem_wdata, em.wdata);
            end
            acks = {dbg_ack, d_ack, if_ack};
            if (ack_q.size() != 0 && ack_q[0].due == cyc) begin
                am = ack_q.pop_front();
                chk("ack", {5'd0, acks}, {5'd0, am.port});
                if (am.chk_rd) chk("rdata", rdata, am.rd);
            end else if (acks != 3'b000) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack cycle %0d: got %b expected 000", cyc, acks);
            end
            if (done) begin
                chk("exp_q_empty", 8'(exp_q.size()), 8'd0);
                chk("ack_q_empty", 8'(ack_q.size()), 8'd0);
                finished = 1'b1;
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue this cycle's expected grant and, if one is granted, next cycle's ack.
    task automatic sched(input logic [2:0] g, input logic chk_h, input logic h,
                         input logic we, input logic chk_a, input logic [7:0] a,
                         input logic [7:0] wd, input logic chk_rd, input logic [7:0] rd,
                         input logic push_ack);
        exp_t e;
        ack_t k;
        e.cyc = cyc; e.gnt = g; e.chk_h = chk_h; e.halt = h;
        e.we = we; e.chk_a = chk_a; e.addr = a; e.wdata = wd;
        exp_q.push_back(e);
        if (g != G_NO && push_ack) begin
            k.due = cyc + 1; k.port = g; k.chk_rd = chk_rd; k.rd = rd;
            ack_q.push_back(k);
        end
    endtask

    task automatic set_if(input logic r, input logic [7:0] a);
        if_req = r; if_addr = a;
    endtask

    task automatic set_d(input logic r, input logic we, input logic [7:0] a, input logic [7:0] wd);
        d_req = r; d_we = we; d_addr = a; d_wdata = wd;
    endtask

    task automatic set_dbg(input logic r, input logic we, input logic [7:0] a, input logic [7:0] wd);
        dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
    endtask

    // Driver: one directed vector per cycle.
    initial begin
        cyc = 0; checks = 0; errors = 0; done = 1'b0; finished = 1'b0;
        rst_n = 1'b0; mem_init = 1'b1; dbg_halt = 1'b0;
        set_if(1'b1, 8'h05);
        set_d(1'b1, 1'b1, 8'h40, 8'h77);
        set_dbg(1'b1, 1'b1, 8'h10, 8'h11);
        tick();

        // reset held with every requester active
        sched(G_NO, 1, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 1); tick();
        sched(G_NO, 1, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 1); tick();

        // release: debug wins the first cycle
        rst_n = 1'b1; mem_init = 1'b0;
        sched(G_DBG, 1, 0, 1, 1, 8'h10, 8'h11, 0, 8'h00, 1); tick();

        // idle: address holds last driven value
        set_if(1'b0, 8'h05); set_d(1'b0, 1'b0, 8'h40, 8'h00); set_dbg(1'b0, 1'b0, 8'h10, 8'h00);
        sched(G_NO, 1, 0, 0, 1, 8'h10, 8'h00, 0, 8'h00, 1); tick();

        // back-to-back fetches
        set_if(1'b1, 8'h05); sched(G_IF, 1, 0, 0, 1, 8'h05, 8'h00, 1, 8'hA3, 1); tick();
        set_if(1'b1, 8'h06); sched(G_IF, 1, 0, 0, 1, 8'h06, 8'h00, 1, 8'hA0, 1); tick();
        set_if(1'b1, 8'h07); sched(G_IF, 1, 0, 0, 1, 8'h07, 8'h00, 1, 8'hA1, 1); tick();
        set_if(1'b0, 8'h07); sched(G_NO, 1, 0, 0, 1, 8'h07, 8'h00, 0, 8'h00, 1); tick();

        // store then load of 0x40 with fetch denied both cycles
        set_if(1'b1, 8'h08); set_d(1'b1, 1'b1, 8'h40, 8'h5C);
        sched(G_D, 1, 0, 1, 1, 8'h40, 8'h5C, 0, 8'h00, 1); tick();
        set_d(1'b1, 1'b0, 8'h40, 8'h5C);
        sched(G_D, 1, 0, 0, 1, 8'h40, 8'h00, 1, 8'h5C, 1); tick();
        set_d(1'b0, 1'b0, 8'h40, 8'h00);
        sched(G_IF, 1, 0, 0, 1, 8'h08, 8'h00, 1, 8'hAE, 1); tick();
        set_if(1'b0, 8'h08);
        sched(G_NO, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1); tick();

        // starvation boost: three data grants then one fetch, twice
        set_if(1'b1, 8'h09); set_d(1'b1, 1'b0, 8'h41, 8'h00);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                sched(G_D, 1, 0, 0, 1, 8'h41, 8'h00, 1, 8'hE7, 1); tick();
            end
            sched(G_IF, 1, 0, 0, 1, 8'h09, 8'h00, 1, 8'hAF, 1); tick();
        end
        set_if(1'b0, 8'h09); set_d(1'b0, 1'b0, 8'h41, 8'h00);
        sched(G_NO, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1); tick();

        // halt with a fetch in flight
        set_if(1'b1, 8'h0A);
        sched(G_IF, 1, 0, 0, 1, 8'h0A, 8'h00, 1, 8'hAC, 1); tick();
        set_if(1'b0, 8'h0A); dbg_halt = 1'b1;
        sched(G_NO, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1); tick();
        set_if(1'b1, 8'h0B); set_d(1'b1, 1'b0, 8'h41, 8'h00);
        sched(G_NO, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1); tick();
        sched(G_NO, 1, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1); tick();
        set_dbg(1'b1, 1'b1, 8'h1F, 8'hFF);
        sched(G_DBG, 1, 1, 1, 1, 8'h1F, 8'hFF, 0, 8'h00, 1); tick();
        set_dbg(1'b1, 1'b0, 8'h1F, 8'hFF);
        sched(G_DBG, 1, 1, 0, 1, 8'h1F, 8'h00, 1, 8'hFF, 1); tick();

        // release halt: data granted in the same cycle
        set_dbg(1'b0, 1'b0, 8'h1F, 8'h00); dbg_halt = 1'b0;
        set_if(1'b0, 8'h0B); set_d(1'b1, 1'b0, 8'h40, 8'h00);
        sched(G_D, 0, 0, 0, 1, 8'h40, 8'h00, 1, 8'h5C, 1); tick();

        // reset right after a load grant: its ack must never appear
        set_if(1'b1, 8'h0C); set_d(1'b1, 1'b0, 8'h41, 8'h00);
        sched(G_D, 1, 0, 0, 1, 8'h41, 8'h00, 1, 8'hE7, 1); tick();
        sched(G_D, 1, 0, 0, 1, 8'h41, 8'h00, 0, 8'h00, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        tick();
        sched(G_NO, 1, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 1); tick();

        // counter restarts from zero: three data grants before fetch is boosted
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sched(G_D, 1, 0, 0, 1, 8'h41, 8'h00, 1, 8'hE7, 1); tick();
        end
        sched(G_IF, 1, 0, 0, 1, 8'h0C, 8'h00, 1, 8'hAA, 1); tick();
        set_if(1'b0, 8'h0C); set_d(1'b0, 1'b0, 8'h41, 8'h00);
        sched(G_NO, 1, 0, 0, 1, 8'h0C, 8'h00, 0, 8'h00, 1); tick();

        done = 1'b1;
    end

endmodule
